// File: rtl/axis_coincidence_reader.sv
// Coincidence front-end: timestamps the first hit, ORs hits over a window, filters on
// group multiplicity, and streams accepted events over AXI-Stream with a dead time after each.
module axis_coincidence_reader #(
    parameter int DIN_WIDTH    = 64,
    parameter int GROUP_WIDTH  = 16,
    parameter int TIME_WIDTH   = 64,
    parameter int WINDOW_WIDTH = 8,
    parameter int DEAD_WIDTH   = 16,
    localparam int NGROUPS     = DIN_WIDTH / GROUP_WIDTH,
    localparam int MULT_WIDTH  = $clog2(NGROUPS + 1)
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [DIN_WIDTH-1:0]            din,
    input  logic [WINDOW_WIDTH-1:0]         cfg_window,
    input  logic [MULT_WIDTH-1:0]           cfg_mult,
    input  logic [DEAD_WIDTH-1:0]           cfg_dead,
    output logic [TIME_WIDTH+DIN_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [31:0]                     event_count,
    output logic [31:0]                     drop_count
);

    typedef enum logic [2:0] {IDLE, COLLECT, EVAL, DECIDE, OUT, DEAD} state_t;

    state_t                          state_q, state_d;
    logic [TIME_WIDTH-1:0]           ts_q, ts_d, time_q, time_d;
    logic [DIN_WIDTH-1:0]            data_q, data_d;
    logic [WINDOW_WIDTH-1:0]         cntr_q, cntr_d, window_q, window_d;
    logic [MULT_WIDTH-1:0]           mult_q, mult_d, multc_q, multc_d, grp_cnt;
    logic [DEAD_WIDTH-1:0]           dead_q, dead_d, deadc_q, deadc_d;
    logic                            tvalid_q, tvalid_d;
    logic [TIME_WIDTH+DIN_WIDTH-1:0] tdata_q, tdata_d;
    logic [31:0]                     event_q, event_d, drop_q, drop_d;

    always_comb begin
        grp_cnt = '0;
        for (int g = 0; g < NGROUPS; g++)
            grp_cnt = grp_cnt + MULT_WIDTH'(|data_q[g*GROUP_WIDTH +: GROUP_WIDTH]);
    end

    always_comb begin
        state_d  = state_q;
        ts_d     = ts_q + TIME_WIDTH'(1);
        time_d   = time_q;
        data_d   = data_q;
        cntr_d   = cntr_q;
        window_d = window_q;
        mult_d   = mult_q;
        multc_d  = multc_q;
        dead_d   = dead_q;
        deadc_d  = deadc_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        event_d  = event_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                if (|din) begin
                    data_d   = din;
                    time_d   = ts_q;
                    cntr_d   = '0;
                    window_d = cfg_window;
                    multc_d  = cfg_mult;
                    deadc_d  = cfg_dead;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                data_d = data_q | din;
                cntr_d = cntr_q + WINDOW_WIDTH'(1);
                if (cntr_q == window_q) state_d = EVAL;
            end
            EVAL: begin
                mult_d  = grp_cnt;
                state_d = DECIDE;
            end
            DECIDE: begin
                if (mult_q >= multc_q) begin
                    tvalid_d = 1'b1;
                    tdata_d  = {time_q, data_q};
                    state_d  = OUT;
                end else begin
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    event_d  = event_q + 32'd1;
                    dead_d   = deadc_q;
                    state_d  = DEAD;
                end else if (|din && drop_q != '1) begin
                    drop_d = drop_q + 32'd1;
                end
            end
            DEAD: begin
                if (dead_q == '0) state_d = IDLE;
                else              dead_d  = dead_q - DEAD_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            ts_q     <= '0;
            time_q   <= '0;
            data_q   <= '0;
            cntr_q   <= '0;
            window_q <= '0;
            mult_q   <= '0;
            multc_q  <= '0;
            dead_q   <= '0;
            deadc_q  <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            event_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            time_q   <= time_d;
            data_q   <= data_d;
            cntr_q   <= cntr_d;
            window_q <= window_d;
            mult_q   <= mult_d;
            multc_q  <= multc_d;
            dead_q   <= dead_d;
            deadc_q  <= deadc_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            event_q  <= event_d;
            drop_q   <= drop_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign event_count   = event_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_axis_coincidence_reader.sv
// Bench for axis_coincidence_reader: per-cycle stimulus tables replayed into the DUT,
// beats compared against an event-level model computed from the timing rules.
module tb_axis_coincidence_reader;
    localparam int DW = 64, GW = 16, TW = 64, WW = 8, DDW = 16, MW = 3, NC = 400;

    logic           aclk = 1'b0, aresetn = 1'b0;
    logic [DW-1:0]  din = '0;
    logic [WW-1:0]  cfg_window = '0;
    logic [MW-1:0]  cfg_mult = '0;
    logic [DDW-1:0] cfg_dead = '0;
    logic [TW+DW-1:0] m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b0;
    logic [31:0]    event_count, drop_count;

    typedef struct { int cyc; logic [TW+DW-1:0] data; } beat_t;

    logic [DW-1:0] din_arr [NC];
    bit            rdy_arr [NC];
    int            w_arr [NC], m_arr [NC], d_arr [NC];
    beat_t         obs_q[$], exp_q[$];
    int            exp_drops, stall_err;
    int            total = 0, bad = 0;

    axis_coincidence_reader dut (
        .aclk(aclk), .aresetn(aresetn), .din(din), .cfg_window(cfg_window),
        .cfg_mult(cfg_mult), .cfg_dead(cfg_dead), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .event_count(event_count), .drop_count(drop_count));

    always #5 aclk = ~aclk;

    task automatic do_reset();
        aresetn = 1'b0; din = '0; m_axis_tready = 1'b0;
        #12;
        @(posedge aclk); #1 aresetn = 1'b1;
    endtask

    task automatic fill(input int w, input int m, input int d);
        for (int k = 0; k < NC; k++) begin
            din_arr[k] = '0; rdy_arr[k] = 1'b1;
            w_arr[k] = w; m_arr[k] = m; d_arr[k] = d;
        end
    endtask

    // Cycle k is the k-th cycle after reset release, so it equals the DUT timestamp.
    task automatic run_case(input int n);
        bit prev_stall;
        logic [TW+DW-1:0] prev_data;
        beat_t b;
        do_reset();
        obs_q.delete(); stall_err = 0; prev_stall = 1'b0; prev_data = '0;
        for (int k = 0; k < n; k++) begin
            din = din_arr[k]; m_axis_tready = rdy_arr[k];
            cfg_window = WW'(w_arr[k]); cfg_mult = MW'(m_arr[k]); cfg_dead = DDW'(d_arr[k]);
            @(negedge aclk);
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data)) stall_err++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                b.cyc = k; b.data = m_axis_tdata; obs_q.push_back(b);
            end
            @(posedge aclk); #1;
        end
    endtask

    // Event-level model: next hit after the free time opens an event lasting w+4 cycles to
    // the first valid cycle; accepted events then wait for tready and a dead time of d+1.
    function automatic void model(input int n);
        int fr, t, h, g;
        logic [DW-1:0] acc;
        beat_t b;
        exp_q.delete(); exp_drops = 0; fr = 0;
        while (fr < n) begin
            t = fr;
            while (t < n && din_arr[t] == '0) t++;
            if (t >= n) break;
            acc = '0;
            for (int i = t; i <= t + w_arr[t] + 1 && i < n; i++) acc |= din_arr[i];
            g = 0;
            for (int q = 0; q < DW / GW; q++) if (acc[q*GW +: GW] != '0) g++;
            if (g >= m_arr[t]) begin
                h = t + w_arr[t] + 4;
                while (h < n && !rdy_arr[h]) begin
                    if (din_arr[h] != '0) exp_drops++;
                    h++;
                end
                if (h >= n) break;
                b.cyc = h; b.data = {TW'(t), acc}; exp_q.push_back(b);
                fr = h + d_arr[t] + 2;
            end else begin
                fr = t + w_arr[t] + 4;
            end
        end
    endfunction

    task automatic test_reset();
        do_reset();
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || event_count !== 0 || drop_count !== 0) begin
            bad++; $display("FAIL reset_state: tvalid=%b tdata=%h ev=%0d drop=%0d want all 0",
                            m_axis_tvalid, m_axis_tdata, event_count, drop_count);
        end
        fill(0, 0, 0);
        din_arr[100] = 64'h1;
        run_case(130);
        total++;
        if (obs_q.size() !== 1) begin
            bad++; $display("FAIL idle_beats: got %0d want 1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].cyc !== 104 || obs_q[0].data !== {64'd100, 64'h1}) begin
                bad++; $display("FAIL ts_100: cyc=%0d data=%h want cyc=104 data=%h",
                                obs_q[0].cyc, obs_q[0].data, {64'd100, 64'h1});
            end
        end
    endtask

    task automatic test_basic();
        fill(3, 2, 0);
        din_arr[10] = 64'h1; din_arr[12] = 64'h100000;
        run_case(40);
        total++;
        if (obs_q.size() !== 1 || event_count !== 1) begin
            bad++; $display("FAIL basic_count: beats=%0d ev=%0d want 1/1", obs_q.size(), event_count);
        end else begin
            total++;
            if (obs_q[0].cyc !== 17 || obs_q[0].data !== {64'd10, 64'h100001}) begin
                bad++; $display("FAIL basic_beat: cyc=%0d data=%h want cyc=17 data=%h",
                                obs_q[0].cyc, obs_q[0].data, {64'd10, 64'h100001});
            end
        end
    endtask

    task automatic test_reject();
        fill(0, 2, 0);
        for (int k = 20; k < NC; k++) m_arr[k] = 1;
        din_arr[10] = 64'h20; din_arr[30] = 64'h20;
        run_case(60);
        total++;
        if (obs_q.size() !== 1) begin
            bad++; $display("FAIL reject_count: beats=%0d want 1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].cyc !== 34 || obs_q[0].data !== {64'd30, 64'h20}) begin
                bad++; $display("FAIL reject_beat: cyc=%0d data=%h want cyc=34 data=%h",
                                obs_q[0].cyc, obs_q[0].data, {64'd30, 64'h20});
            end
        end
        fill(0, 2, 0);
        din_arr[10] = 64'h3;
        run_case(30);
        total++;
        if (obs_q.size() !== 0) begin
            bad++; $display("FAIL same_group: beats=%0d want 0", obs_q.size());
        end
    endtask

    task automatic test_backpressure();
        fill(0, 1, 0);
        din_arr[10] = 64'h1;
        for (int k = 14; k < 24; k++) begin rdy_arr[k] = 1'b0; din_arr[k] = 64'h1; end
        run_case(40);
        total++;
        if (drop_count !== 10) begin
            bad++; $display("FAIL bp_drops: got %0d want 10", drop_count);
        end
        total++;
        if (stall_err !== 0) begin
            bad++; $display("FAIL bp_stable: unstable stall cycles %0d want 0", stall_err);
        end
        total++;
        if (obs_q.size() !== 1 || event_count !== 1) begin
            bad++; $display("FAIL bp_count: beats=%0d ev=%0d want 1/1", obs_q.size(), event_count);
        end else begin
            total++;
            if (obs_q[0].cyc !== 24 || obs_q[0].data !== {64'd10, 64'h1}) begin
                bad++; $display("FAIL bp_beat: cyc=%0d data=%h want cyc=24", obs_q[0].cyc, obs_q[0].data);
            end
        end
    endtask

    task automatic test_dead();
        fill(0, 1, 5);
        for (int k = 10; k < 35; k++) din_arr[k] = 64'h1;
        run_case(60);
        total++;
        if (obs_q.size() < 2) begin
            bad++; $display("FAIL dead_count: beats=%0d want >=2", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].cyc !== 14 || obs_q[1].data[TW+DW-1:DW] !== 64'd21 || obs_q[1].cyc !== 25) begin
                bad++; $display("FAIL dead_gap: h0=%0d t1=%0d h1=%0d want 14/21/25",
                                obs_q[0].cyc, obs_q[1].data[TW+DW-1:DW], obs_q[1].cyc);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill(0, 0, 0);
            for (int k = 0; k < NC - 60; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    din_arr[k] = 64'h1 << $urandom_range(0, 63);
                    if ($urandom_range(0, 1) == 0) din_arr[k] |= 64'h1 << $urandom_range(0, 63);
                end
                rdy_arr[k] = ($urandom_range(0, 9) < 7);
                w_arr[k] = int'($urandom_range(0, 6));
                m_arr[k] = int'($urandom_range(0, 4));
                d_arr[k] = int'($urandom_range(0, 6));
            end
            run_case(NC);
            model(NC);
            total++;
            if (obs_q.size() !== exp_q.size()) begin
                bad++; $display("FAIL rand%0d_count: beats=%0d want %0d", r, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].data !== exp_q[i].data) begin
                    bad++; $display("FAIL rand%0d_beat%0d: cyc=%0d data=%h want cyc=%0d data=%h",
                                    r, i, obs_q[i].cyc, obs_q[i].data, exp_q[i].cyc, exp_q[i].data);
                end
            end
            total++;
            if (event_count !== 32'(exp_q.size()) || drop_count !== 32'(exp_drops) || stall_err !== 0) begin
                bad++; $display("FAIL rand%0d_ctrs: ev=%0d drop=%0d stall=%0d want %0d/%0d/0",
                                r, event_count, drop_count, stall_err, exp_q.size(), exp_drops);
            end
        end
    endtask

    task automatic test_async_reset();
        int seen, n;
        // Reset in the middle of collecting.
        do_reset();
        cfg_window = 8'd5; cfg_mult = '0; cfg_dead = '0; m_axis_tready = 1'b1;
        din = 64'h1; @(posedge aclk); #1 din = '0;
        @(posedge aclk); #3 aresetn = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin @(negedge aclk); if (m_axis_tvalid) seen++; end
        total++;
        if (seen !== 0 || event_count !== 0) begin
            bad++; $display("FAIL rst_collect: tvalid cycles=%0d ev=%0d want 0/0", seen, event_count);
        end
        // Reset while a beat is stalled.
        do_reset();
        cfg_window = '0; cfg_mult = '0; cfg_dead = '0; m_axis_tready = 1'b0;
        din = 64'h1;
        n = 0;
        while (!m_axis_tvalid && n < 20) begin @(posedge aclk); #1 n++; end
        @(posedge aclk); #1;
        total++;
        if (m_axis_tvalid !== 1'b1 || drop_count === 0) begin
            bad++; $display("FAIL rst_out_pre: tvalid=%b drop=%0d want 1/>0", m_axis_tvalid, drop_count);
        end
        #2 aresetn = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || drop_count !== 0) begin
            bad++; $display("FAIL rst_out_async: tvalid=%b tdata=%h drop=%0d want 0/0/0",
                            m_axis_tvalid, m_axis_tdata, drop_count);
        end
        din = '0; m_axis_tready = 1'b1;
        @(posedge aclk); #1 aresetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin @(negedge aclk); if (m_axis_tvalid) seen++; end
        total++;
        if (seen !== 0 || event_count !== 0 || drop_count !== 0) begin
            bad++; $display("FAIL rst_out_after: tvalid cycles=%0d ev=%0d drop=%0d want 0/0/0",
                            seen, event_count, drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_backpressure();
        test_dead();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
